// File: rtl/byte_comp_pkg.sv
// Shared definitions for the byte computer run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state encoding, default address/data widths, CPU reset pulse length.
package byte_comp_pkg;

    localparam int AW_DEF         = 5;
    localparam int DW_DEF         = 8;
    localparam int CPU_RST_CYCLES = 2;

    // Plain vector encoding so legacy code can compare against the constants directly.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_CPU_RST = 3'd2;
    localparam state_t ST_RUN     = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/seq_mem_mux.sv
// Memory port mux: hands the single memory port to the loader, the CPU or host readback.
// Latency: purely combinational, selected by the registered sequencer state.
// Backpressure: none; the owner of the port is decided entirely by state.
// Ports: i_state selects; host/loader and CPU request sides in; mem_* and cpu_idata out.
module seq_mem_mux
    import byte_comp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  state_t        i_state,
    input  logic [AW-1:0] i_ptr,
    input  logic          i_host_wr_valid,
    input  logic [DW-1:0] i_host_wr_data,
    input  logic [AW-1:0] i_host_rd_addr,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_odata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [DW-1:0] o_cpu_idata
);

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_cpu_idata = '0;
        case (i_state)
            ST_RUN: begin
                o_mem_we    = i_cpu_we;
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_odata;
                o_cpu_idata = i_mem_rdata;
            end
            ST_LOAD: begin
                o_mem_we    = i_host_wr_valid;
                o_mem_addr  = i_ptr;
                o_mem_wdata = i_host_wr_data;
            end
            ST_IDLE, ST_DONE: begin
                // Read-only: the host readback address drives the async read port.
                o_mem_addr  = i_host_rd_addr;
            end
            default: begin
                o_mem_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/byte_mem_sequencer.sv
// Run controller: loads program memory, resets and runs the CPU to halt/watchdog, then serves readback.
// Latency: host readback 1 cycle (req -> dvalid); CPU reset pulse CPU_RST_CYCLES cycles.
// Backpressure: host_wr_ready high only in LOAD; reads outside IDLE/DONE are dropped, not stalled.
// Ports: host load/run/readback side, status (busy/done/timeout/run_cycles), CPU control and data, memory port.
module byte_mem_sequencer
    import byte_comp_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_load_start,
    input  logic          host_wr_valid,
    output logic          host_wr_ready,
    input  logic [DW-1:0] host_wr_data,
    input  logic          host_run,
    input  logic          host_rd_req,
    input  logic [AW-1:0] host_rd_addr,
    output logic [DW-1:0] host_rd_data,
    output logic          host_rd_dvalid,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] run_cycles,
    output logic          cpu_rst_n,
    output logic          cpu_start,
    input  logic          cpu_halt,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_odata,
    output logic [DW-1:0] cpu_idata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0]  RST_LAST = 2'(CPU_RST_CYCLES - 1);
    localparam logic [CW:0] WD_LIMIT = (CW + 1)'(MAX_CYCLES);

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [CW-1:0] r_run_cycles;
    logic          r_timeout;
    logic [1:0]    r_rst_cnt;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_dvalid;

    logic [CW-1:0] w_cnt_inc;
    logic          w_wd_hit;
    logic          w_host_owns;

    // Saturating count of RUN cycles, including the cycle in which the run ends.
    assign w_cnt_inc   = (r_run_cycles == '1) ? r_run_cycles : r_run_cycles + 1'b1;
    assign w_wd_hit    = ({1'b0, w_cnt_inc} >= WD_LIMIT);
    assign w_host_owns = (r_state == ST_IDLE) || (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
            r_rst_cnt    <= '0;
            r_rd_data    <= '0;
            r_rd_dvalid  <= 1'b0;
        end else begin
            r_rd_dvalid <= 1'b0;
            if (w_host_owns && host_rd_req) begin
                r_rd_data   <= mem_rdata;
                r_rd_dvalid <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // Load takes priority over run when both are requested together.
                    if (host_load_start) begin
                        r_state   <= ST_LOAD;
                        r_ptr     <= '0;
                        r_timeout <= 1'b0;
                    end else if (host_run) begin
                        r_state      <= ST_CPU_RST;
                        r_run_cycles <= '0;
                        r_timeout    <= 1'b0;
                        r_rst_cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    // A restart still lets a byte offered in the same cycle land at the old pointer.
                    if (host_load_start) begin
                        r_ptr <= '0;
                    end else if (host_wr_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_ptr == '1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_CPU_RST: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_run_cycles <= w_cnt_inc;
                    // Halt beats the watchdog when both land in the same cycle.
                    if (cpu_halt) begin
                        r_state   <= ST_DONE;
                        r_timeout <= 1'b0;
                    end else if (w_wd_hit) begin
                        r_state   <= ST_DONE;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_wr_ready  = (r_state == ST_LOAD);
    assign busy           = (r_state == ST_LOAD) || (r_state == ST_CPU_RST) || (r_state == ST_RUN);
    assign done           = (r_state == ST_DONE);
    assign timeout        = r_timeout;
    assign run_cycles     = r_run_cycles;
    // CPU stays out of reset in DONE so its final state can be inspected.
    assign cpu_rst_n      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign cpu_start      = (r_state == ST_RUN);
    assign host_rd_data   = r_rd_data;
    assign host_rd_dvalid = r_rd_dvalid;

    seq_mem_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .i_state         (r_state),
        .i_ptr           (r_ptr),
        .i_host_wr_valid (host_wr_valid),
        .i_host_wr_data  (host_wr_data),
        .i_host_rd_addr  (host_rd_addr),
        .i_cpu_we        (cpu_we),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_odata     (cpu_odata),
        .i_mem_rdata     (mem_rdata),
        .o_mem_we        (mem_we),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .o_cpu_idata     (cpu_idata)
    );

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Bench for byte_mem_sequencer with a 32x8 memory and a small two-phase CPU model.
// CPU model: opcode in bits [7:5], address in [4:0]; LD=0 ADD=1 ST=2 JMP=3 HLT=7.
// Each instruction takes a fetch and an execute cycle; halt is a registered flag.
module tb_byte_mem_sequencer;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_load_start = 1'b0;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [DW-1:0] host_wr_data = '0;
    logic          host_run = 1'b0;
    logic          host_rd_req = 1'b0;
    logic [AW-1:0] host_rd_addr = '0;
    logic [DW-1:0] host_rd_data;
    logic          host_rd_dvalid;
    logic          busy, done, timeout;
    logic [CW-1:0] run_cycles;
    logic          cpu_rst_n, cpu_start, cpu_halt, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_odata, cpu_idata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    byte_mem_sequencer #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_load_start(host_load_start), .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
        .host_run(host_run), .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .host_rd_dvalid(host_rd_dvalid),
        .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles),
        .cpu_rst_n(cpu_rst_n), .cpu_start(cpu_start), .cpu_halt(cpu_halt),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_idata(cpu_idata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory array: synchronous write, asynchronous read. Not touched by rst_n.
    logic [DW-1:0] mem [32];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // CPU model.
    logic [AW-1:0] c_pc;
    logic [7:0]    c_ir, c_acc;
    logic          c_phase, c_halted;
    wire           c_active = cpu_start && !c_halted;
    always @(posedge clk) begin
        if (!cpu_rst_n) begin
            c_pc <= '0; c_ir <= '0; c_acc <= '0; c_phase <= 1'b0; c_halted <= 1'b0;
        end else if (c_active) begin
            if (!c_phase) begin
                c_ir    <= cpu_idata;
                c_phase <= 1'b1;
            end else begin
                c_phase <= 1'b0;
                c_pc    <= c_pc + 1'b1;
                case (c_ir[7:5])
                    3'd0: c_acc <= cpu_idata;
                    3'd1: c_acc <= c_acc + cpu_idata;
                    3'd3: c_pc  <= c_ir[4:0];
                    3'd7: c_halted <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
    assign cpu_addr  = c_phase ? c_ir[4:0] : c_pc;
    assign cpu_we    = c_active && c_phase && (c_ir[7:5] == 3'd2);
    assign cpu_odata = c_acc;
    assign cpu_halt  = c_halted;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Readback scoreboard: expected byte and the cycle in which dvalid must be seen.
    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] due;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    always @(negedge clk) begin
        if (host_rd_dvalid) begin
            if (sb_q.size() == 0) begin
                check("rd_spurious_dvalid", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check("rd_data", {24'd0, host_rd_data}, {24'd0, e.data});
                check("rd_latency", cyc, e.due);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            rd_exp_t e;
            e = sb_q.pop_front();
            check("rd_missing_dvalid", 32'd0, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] img [32];

    // Starts from posedge+1; leaves at posedge+1 in IDLE after 32 writes.
    task automatic load_img(input logic with_run);
        host_load_start = 1'b1;
        host_run        = with_run;
        tick();
        host_load_start = 1'b0;
        host_run        = 1'b0;
        host_wr_valid   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            host_wr_data = img[i];
            @(negedge clk);
            check("ld_addr", {27'd0, mem_addr}, i);
            if (i == 0) begin
                check("ld_wr_ready", {31'd0, host_wr_ready}, 32'd1);
                check("ld_we", {31'd0, mem_we}, 32'd1);
                check("ld_done_clr", {31'd0, done}, 32'd0);
                check("ld_timeout_clr", {31'd0, timeout}, 32'd0);
            end
            tick();
        end
        host_wr_valid = 1'b0;
        @(negedge clk);
        check("ld_exit_ready", {31'd0, host_wr_ready}, 32'd0);
        check("ld_exit_busy", {31'd0, busy}, 32'd0);
        tick();
    endtask

    // Pulses host_run and checks the 2-cycle CPU reset and RUN entry, plus a dropped read in RUN.
    task automatic start_run();
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        @(negedge clk);
        check("cpurst_c1_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("cpurst_busy", {31'd0, busy}, 32'd1);
        check("cpurst_done_clr", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("cpurst_c2_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk);
        check("run_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("run_start", {31'd0, cpu_start}, 32'd1);
        tick();
        host_rd_req  = 1'b1;
        host_rd_addr = 5'd3;
        tick();
        host_rd_req = 1'b0;
        @(negedge clk);
        check("run_rd_dropped", {31'd0, host_rd_dvalid}, 32'd0);
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("wait_done", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] d);
        rd_exp_t e;
        host_rd_req  = 1'b1;
        host_rd_addr = a;
        e.data = d;
        e.due  = cyc + 1;
        sb_q.push_back(e);
        tick();
        host_rd_req = 1'b0;
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t vecs [6];

    initial begin
        #400000;
        $display("FAIL global_timeout: sim did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd5,  8'h05};
        vecs[1] = '{5'd31, 8'h1F};
        vecs[2] = '{5'd0,  8'h00};
        vecs[3] = '{5'd16, 8'h10};
        vecs[4] = '{5'd17, 8'h11};
        vecs[5] = '{5'd30, 8'h1E};

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
        check("rst_dvalid", {31'd0, host_rd_dvalid}, 32'd0);
        check("rst_rd_data", {24'd0, host_rd_data}, 32'd0);
        check("rst_wr_ready", {31'd0, host_wr_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load ramp 0x00..0x1F, then back-to-back table readback.
        for (int i = 0; i < 32; i++) img[i] = 8'(i);
        load_img(1'b0);
        for (int k = 0; k < 6; k++) rd(vecs[k].addr, vecs[k].exp);
        repeat (3) tick();

        // Add program: LD [20]; ADD [21]; ST [22]; HLT with [20]=3, [21]=4.
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[0] = 8'h14; img[1] = 8'h35; img[2] = 8'h56; img[3] = 8'hE0;
        img[20] = 8'h03; img[21] = 8'h04;
        load_img(1'b0);
        start_run();
        wait_done();
        check("add_timeout", {31'd0, timeout}, 32'd0);
        // 4 instructions x 2 cycles + 1 cycle for the registered halt flag.
        check("add_run_cycles", {16'd0, run_cycles}, 32'd9);
        check("add_done_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("add_done_start", {31'd0, cpu_start}, 32'd0);
        check("add_done_busy", {31'd0, busy}, 32'd0);
        rd(5'd22, 8'h07);
        rd(5'd20, 8'h03);
        repeat (2) tick();

        // Endless jump: watchdog ends the run after MAXC cycles.
        for (int i = 0; i < 32; i++) img[i] = 8'h60;
        load_img(1'b0);
        start_run();
        wait_done();
        check("wd_timeout", {31'd0, timeout}, 32'd1);
        check("wd_run_cycles", {16'd0, run_cycles}, MAXC);
        check("wd_done", {31'd0, done}, 32'd1);

        // Load and run requested together from DONE: load wins, done/timeout clear.
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[0] = 8'h14; img[1] = 8'h35; img[2] = 8'h56; img[3] = 8'hE0;
        img[20] = 8'h03; img[21] = 8'h04;
        load_img(1'b1);

        // Reset in the middle of a run: abort to IDLE, memory untouched.
        start_run();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("midrst_cpu_start", {31'd0, cpu_start}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_run_cycles", {16'd0, run_cycles}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(5'd0, 8'h14);
        rd(5'd20, 8'h03);
        rd(5'd21, 8'h04);
        rd(5'd22, 8'h00);
        repeat (3) tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_mem_sequencer.md
Name: byte_mem_sequencer

Overview:
- Run controller and memory arbiter for the 8-bit byte computer and its 32x8 program/data memory.
- Shares the single memory port between a host loader/readback port and the CPU.
- Sequences the full flow: load program, reset CPU, run until halt or watchdog timeout, release memory for readback.
- Sits between the top level, the CPU instance and the memory array.

Parameters:
AW, 5, memory address width (depth 2**AW bytes)
DW, 8, data width
CW, 16, run cycle counter width
MAX_CYCLES, 4096, watchdog limit in clk cycles spent in RUN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
host_load_start  in  1  pulse: begin program load at address 0
host_wr_valid  in  1  host write byte valid
host_wr_ready  out  1  sequencer accepts byte (LOAD state only)
host_wr_data  in  DW  program byte
host_run  in  1  pulse: reset and start CPU
host_rd_req  in  1  pulse: read memory byte
host_rd_addr  in  AW  readback address
host_rd_data  out  DW  readback data, registered
host_rd_dvalid  out  1  one-cycle pulse, host_rd_data valid
busy  out  1  state is LOAD, CPU_RST or RUN
done  out  1  run finished, held in DONE
timeout  out  1  run ended by watchdog, held with done
run_cycles  out  CW  clk cycles spent in last RUN, saturating
cpu_rst_n  out  1  CPU reset, active-low
cpu_start  out  1  CPU start
cpu_halt  in  1  CPU halt flag
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_odata  in  DW  CPU write data
cpu_idata  out  DW  memory read data to CPU
mem_we  out  1  memory write enable, synchronous write
mem_addr  out  AW  memory address, asynchronous read
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- State machine: IDLE, LOAD, CPU_RST, RUN, DONE.
- Reset: state=IDLE; load pointer=0; host_rd_dvalid=0; host_rd_data=0; done=0; timeout=0; run_cycles=0; cpu_rst_n=0; cpu_start=0.
- Reset mid-operation aborts any run or load; memory contents are untouched.

State transitions:
- IDLE/DONE + host_load_start -> LOAD; pointer=0; done and timeout cleared.
- IDLE/DONE + host_run -> CPU_RST; run_cycles=0; done and timeout cleared.
- host_load_start and host_run in the same cycle: load wins.
- LOAD: host_wr_ready=1. Each cycle with host_wr_valid=1 writes mem[pointer] and increments pointer.
- LOAD exits to IDLE after the byte written at address 2**AW-1 (pointer wraps to 0).
- host_load_start during LOAD restarts the pointer at 0. host_run and host_rd_req during LOAD are ignored.
- CPU_RST: cpu_rst_n=0 for exactly 2 cycles, then RUN.
- RUN: cpu_rst_n=1, cpu_start=1; run_cycles increments each cycle, saturating at 2**CW-1.
  - cpu_halt=1 -> DONE, timeout=0.
  - Count reaching MAX_CYCLES -> DONE, timeout=1.
  - If both occur in the same cycle, halt wins (timeout=0).
- DONE: cpu_start=0, cpu_rst_n=1 (CPU state preserved), done=1.

Memory mux (combinational on registered state):
- RUN: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_odata, cpu_idata=mem_rdata.
- LOAD: mem_addr=pointer, mem_we=host_wr_valid, mem_wdata=host_wr_data.
- IDLE/DONE: mem_addr=host_rd_addr, mem_we=0.
- All other states: mem_we=0. cpu_we is ignored outside RUN.

Host read:
- host_rd_req in IDLE or DONE: mem_rdata is captured into host_rd_data at the clock edge; host_rd_dvalid=1 for the next cycle (latency 1).
- A read request in any other state is dropped; host_rd_dvalid stays 0.
- Back-to-back requests give back-to-back dvalid pulses.

Decomposition:
- Shared package byte_comp_pkg holds:
  - state enum (IDLE, LOAD, CPU_RST, RUN, DONE)
  - AW/DW defaults
  - CPU_RST_CYCLES=2
- One sub-module, seq_mem_mux: purely combinational port mux selected by state.
- FSM, pointer, counter and read register stay in the top module.

Test Plan:
- Load 32 bytes 0x00..0x1F with valid held high -> 32 writes in 32 cycles, mem_addr 0..31, return to IDLE, host_wr_ready low afterwards.
- Load, then read addresses 5 and 31 -> host_rd_data=0x05 then 0x1F, each dvalid one cycle after its req.
- Run a program: LD [20]=3; ADD [21]=4; ST [22]; halt -> done=1, timeout=0; readback of address 22 returns 0x07; run_cycles matches the CPU cycle count.
- Program with an endless unconditional jump, MAX_CYCLES=64 -> DONE after 64 RUN cycles, timeout=1, run_cycles=64.
- rst_n=0 during RUN -> next cycle IDLE, cpu_rst_n=0, cpu_start=0; memory contents are unchanged on readback.
- host_load_start and host_run in the same cycle from DONE -> LOAD entered, done cleared. host_rd_req during RUN -> no dvalid.
